// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch / data) in front of one single-port memory.
// It runs one access at a time, uses anti-starvation arbitration, and supports a halt-and-dump sequence.
module mem_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        dm_stall,
  input  logic        halt,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic        mem_createdump
);
  typedef enum logic [2:0] {IDLE, ACCESS, DONE, DUMP, HALTED} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_DM   = 1'b1;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        owner;
  logic        wr_q;
  logic        last_if_denied;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        grant;
  logic        grant_dm;
  logic        last_cycle;
  logic        access;

  always_comb begin
    grant      = (state == IDLE) && !halt && (if_req || dm_req);
    grant_dm   = dm_req && !(if_req && last_if_denied);
    last_cycle = (state == ACCESS) && (cnt == 4'd0);
    state_nxt  = state;
    case (state)
      IDLE: begin
        if (halt) state_nxt = DUMP;
        else if (grant) state_nxt = ACCESS;
      end
      ACCESS: if (last_cycle) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      DUMP:    state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      owner          <= OWN_IF;
      wr_q           <= 1'b0;
      last_if_denied <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        cnt   <= CNT_LOAD;
        owner <= grant_dm ? OWN_DM : OWN_IF;
        wr_q  <= grant_dm && dm_wr;
        // Fetch losing a conflict earns it the next conflict; winning clears the debt.
        if (!grant_dm) last_if_denied <= 1'b0;
        else if (if_req) last_if_denied <= 1'b1;
      end else if ((state == ACCESS) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Request capture: address/data only matter while ACCESS drives them out.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_q  <= grant_dm ? dm_addr : if_addr;
      wdata_q <= grant_dm ? dm_wdata : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_rdata <= 16'h0000;
      dm_rdata <= 16'h0000;
    end else if (last_cycle && !wr_q) begin
      if (owner == OWN_DM) dm_rdata <= mem_data_out;
      else if_rdata <= mem_data_out;
    end
  end

  always_comb begin
    access         = (state == ACCESS);
    mem_enable     = access;
    mem_wr         = last_cycle && wr_q;
    mem_addr       = access ? addr_q : 16'h0000;
    mem_data_in    = access ? wdata_q : 16'h0000;
    mem_createdump = (state == DUMP);
    if_done        = (state == DONE) && (owner == OWN_IF);
    dm_done        = (state == DONE) && (owner == OWN_DM);
    if_stall       = if_req && !if_done;
    dm_stall       = dm_req && !dm_done;
  end
endmodule
